// File: rtl/adc_lvds_serializer.sv
// Bit-rate SDR serializer: NCH channels x 2 lanes plus a frame lane, one bit per lane per clock.
// Optional TX_TEST_PATTERN_EN adds iTestPat, which loads fixed receiver calibration words.
module adc_lvds_serializer #(
  parameter int                NCH       = 4,
  parameter int                DW        = 14,
  parameter int                WW        = 16,
  parameter logic [WW/2-1:0]   FRAME_PAT = 8'hF0,
  parameter int                UCNT_W    = 16
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
`ifdef TX_TEST_PATTERN_EN
  input  logic                iTestPat,
`endif
  input  logic [DW-1:0]       iData [NCH],
  input  logic                iValid,
  output logic                oReady,
  output logic [2*NCH-1:0]    oLane,
  output logic                oFrame,
  output logic                oFrameStart,
  output logic                oUnderrun,
  output logic [UCNT_W-1:0]   oUnderrunCnt
);

  localparam int BPF = WW / 2;
  localparam int SW  = (BPF > 1) ? $clog2(BPF) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [SW-1:0]   slot;
  logic [SW-1:0]   fidx;
  logic            full;
  logic [DW-1:0]   hold [NCH];
  logic [WW-1:0]   sh   [NCH];
  logic [WW-1:0]   nw   [NCH];
  logic            tp;
  logic            last;
  logic            load;
  logic            accept;
  logic            take_hold;
  logic            take_in;
  logic            under;

  function automatic logic [WW-1:0] pad_word(input logic [DW-1:0] s);
    return {s, {(WW-DW){1'b0}}};
  endfunction

  function automatic logic [DW-1:0] test_word(input int c);
    case (c)
      2:       return DW'(14'h3FFF);
      3:       return DW'(14'h1555);
      default: return '0;
    endcase
  endfunction

`ifdef TX_TEST_PATTERN_EN
  assign tp = iTestPat;
`else
  assign tp = 1'b0;
`endif

  assign last      = (state == RUN) && (slot == SW'(BPF-1));
  assign load      = ((state == IDLE) || last) && iEn;
  // A slot-7 accept is only safe when that edge really loads a frame, otherwise the held sample would be overwritten.
  assign oReady    = ~iRst & (~full | (last & iEn & ~tp));
  assign accept    = iValid & oReady;
  assign take_hold = load & ~tp & full;
  assign take_in   = load & ~tp & ~full & accept;
  assign under     = load & ~tp & ~full & ~accept;
  assign fidx      = SW'(BPF-2) - slot;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      nw[c] = '0;
      if (tp)
        nw[c] = pad_word(test_word(c));
      else if (full)
        nw[c] = pad_word(hold[c]);
      else if (accept)
        nw[c] = pad_word(iData[c]);
    end
  end

  // Holding register data carries no reset; the full flag alone says whether it is meaningful.
  always_ff @(posedge iClk) begin
    if (accept && !take_in)
      hold <= iData;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state        <= IDLE;
      slot         <= '0;
      full         <= 1'b0;
      oLane        <= '0;
      oFrame       <= 1'b0;
      oFrameStart  <= 1'b0;
      oUnderrun    <= 1'b0;
      oUnderrunCnt <= '0;
      for (int c = 0; c < NCH; c++) sh[c] <= '0;
    end else begin
      oUnderrun <= under;
      if (under && (oUnderrunCnt != '1))
        oUnderrunCnt <= oUnderrunCnt + UCNT_W'(1);

      if (take_hold)
        full <= accept;
      else if (accept && !take_in)
        full <= 1'b1;

      if (load) begin
        state       <= RUN;
        slot        <= '0;
        oFrame      <= FRAME_PAT[BPF-1];
        oFrameStart <= 1'b1;
        for (int c = 0; c < NCH; c++) begin
          oLane[2*c]   <= nw[c][WW-1];
          oLane[2*c+1] <= nw[c][WW-2];
          sh[c]        <= nw[c] << 2;
        end
      end else if ((state == RUN) && !last) begin
        slot        <= slot + SW'(1);
        oFrame      <= FRAME_PAT[fidx];
        oFrameStart <= 1'b0;
        for (int c = 0; c < NCH; c++) begin
          oLane[2*c]   <= sh[c][WW-1];
          oLane[2*c+1] <= sh[c][WW-2];
          sh[c]        <= sh[c] << 2;
        end
      end else begin
        state       <= IDLE;
        slot        <= '0;
        oLane       <= '0;
        oFrame      <= 1'b0;
        oFrameStart <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_lvds_serializer.sv
// Directed bench for adc_lvds_serializer: vector table plus hand-written multi-frame sequences.
module tb_adc_lvds_serializer;
  localparam int NCH = 4;
  localparam int DW  = 14;
  localparam int WW  = 16;
  localparam int UW  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              valid;
  logic              ready;
  logic              frame;
  logic              fs;
  logic              und;
  logic [DW-1:0]     data [NCH];
  logic [2*NCH-1:0]  lane;
  logic [UW-1:0]     cnt;
`ifdef TX_TEST_PATTERN_EN
  logic              tpat;
`endif

  int checks   = 0;
  int failures = 0;

  logic [15:0] rxw [NCH];
  logic [7:0]  fp;

  always #5 clk = ~clk;

  adc_lvds_serializer #(.NCH(NCH), .DW(DW), .WW(WW), .FRAME_PAT(8'hF0), .UCNT_W(UW)) dut (
    .iClk(clk),
    .iRst(rst),
    .iEn(en),
`ifdef TX_TEST_PATTERN_EN
    .iTestPat(tpat),
`endif
    .iData(data),
    .iValid(valid),
    .oReady(ready),
    .oLane(lane),
    .oFrame(frame),
    .oFrameStart(fs),
    .oUnderrun(und),
    .oUnderrunCnt(cnt)
  );

  typedef struct {
    logic       en;
    logic       v;
    logic [13:0] d;
    logic [7:0] lane;
    logic       fr;
    logic       fs;
    logic       und;
    logic       rdy;
    logic [3:0] cnt;
  } vec_t;

  vec_t vt[$];

  function automatic void addv(input logic e, input logic v, input logic [13:0] d,
                               input logic [7:0] l, input logic fr, input logic f,
                               input logic u, input logic r, input logic [3:0] c);
    vec_t x;
    x.en = e; x.v = v; x.d = d; x.lane = l; x.fr = fr; x.fs = f; x.und = u; x.rdy = r; x.cnt = c;
    vt.push_back(x);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch0(input logic [13:0] d);
    for (int c = 0; c < NCH; c++) data[c] = (c == 0) ? d : '0;
  endtask

  function automatic logic [13:0] stream_val(input int c, input int n);
    return 14'((c << 12) | n);
  endfunction

  task automatic set_stream(input int n);
    for (int c = 0; c < NCH; c++) data[c] = stream_val(c, n);
  endtask

  // Receiver view: lane A carries the odd word bits, lane B the even ones, MSB first.
  task automatic take(input int s);
    for (int c = 0; c < NCH; c++) begin
      rxw[c][15-2*s] = lane[2*c];
      rxw[c][14-2*s] = lane[2*c+1];
    end
  endtask

  task automatic check_words(input string tag, input int n);
    for (int c = 0; c < NCH; c++)
      check($sformatf("%s ch%0d word", tag, c), 32'(rxw[c]), 32'({stream_val(c, n), 2'b00}));
  endtask

  initial begin
    int n;
    int acc;
    int undn;
    logic will;
    logic [7:0] l2 [8];

    rst = 1'b1; en = 1'b0; valid = 1'b0; set_ch0('0);
`ifdef TX_TEST_PATTERN_EN
    tpat = 1'b0;
`endif
    fp = 8'hF0;
    l2 = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h03, 8'h02, 8'h00, 8'h00};

    // Three underrun frames, then 2AAA bypassed at slot 7, then 1234 held from slot 2.
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < 8; s++)
        addv(1, 0, 14'h0, 8'h00, fp[7-s], s == 0, s == 0, 1, 4'(f + 1));
    addv(1, 1, 14'h2AAA, 8'h01, 1, 1, 0, 1, 3);
    addv(1, 0, 14'h0,    8'h01, 1, 0, 0, 1, 3);
    addv(1, 0, 14'h0,    8'h01, 1, 0, 0, 1, 3);
    addv(1, 1, 14'h1234, 8'h01, 1, 0, 0, 0, 3);
    addv(1, 0, 14'h0,    8'h01, 0, 0, 0, 0, 3);
    addv(1, 0, 14'h0,    8'h01, 0, 0, 0, 0, 3);
    addv(1, 0, 14'h0,    8'h01, 0, 0, 0, 0, 3);
    addv(1, 0, 14'h0,    8'h00, 0, 0, 0, 1, 3);
    for (int s = 0; s < 8; s++)
      addv(1, 0, 14'h0, l2[s], fp[7-s], s == 0, 0, 1, 3);

    repeat (2) @(posedge clk);
    #1;
    check("reset lane", 32'(lane), 0);
    check("reset frame", 32'(frame), 0);
    check("reset fs", 32'(fs), 0);
    check("reset und", 32'(und), 0);
    check("reset cnt", 32'(cnt), 0);
    check("reset ready", 32'(ready), 0);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      en = vt[i].en; valid = vt[i].v; set_ch0(vt[i].d);
      tick;
      check($sformatf("vec%0d lane", i),  32'(lane),  32'(vt[i].lane));
      check($sformatf("vec%0d frame", i), 32'(frame), 32'(vt[i].fr));
      check($sformatf("vec%0d fs", i),    32'(fs),    32'(vt[i].fs));
      check($sformatf("vec%0d und", i),   32'(und),   32'(vt[i].und));
      check($sformatf("vec%0d ready", i), 32'(ready), 32'(vt[i].rdy));
      check($sformatf("vec%0d cnt", i),   32'(cnt),   32'(vt[i].cnt));
    end

    // Continuous valid: one sample per frame once the holding entry is full.
    n = 1; valid = 1'b1; set_stream(n); acc = 0; undn = 0;
    for (int cyc = 0; cyc < 32; cyc++) begin
      int s;
      s = cyc % 8;
      will = ready;
      tick;
      if (will) begin acc++; n++; set_stream(n); end
      take(s);
      if (und) undn++;
      if (s == 3) check($sformatf("stream ready slot3 c%0d", cyc), 32'(ready), 0);
      if (s == 7) begin
        check($sformatf("stream ready slot7 c%0d", cyc), 32'(ready), 1);
        check_words($sformatf("stream f%0d", cyc / 8), cyc / 8 + 1);
      end
    end
    check("stream accepts", 32'(acc), 5);
    check("stream underruns", 32'(undn), 0);
    check("stream cnt", 32'(cnt), 3);

    // Enable dropped mid-frame: frame completes, then idle; held sample goes first on re-entry.
    valid = 1'b0;
    tick; take(0);
    check("stop fs", 32'(fs), 1);
    valid = 1'b1;
    tick; take(1);
    valid = 1'b0;
    tick; take(2);
    tick; take(3);
    en = 1'b0;
    for (int s = 4; s < 8; s++) begin
      tick; take(s);
      check($sformatf("stop frame slot%0d", s), 32'(frame), 32'(fp[7-s]));
    end
    check_words("stopped frame", 5);
    for (int i = 0; i < 4; i++) begin
      tick;
      check($sformatf("idle%0d lane", i), 32'(lane), 0);
      check($sformatf("idle%0d frame", i), 32'(frame), 0);
      check($sformatf("idle%0d fs", i), 32'(fs), 0);
    end
    check("idle ready full", 32'(ready), 0);
    en = 1'b1; undn = 0;
    for (int s = 0; s < 8; s++) begin
      tick; take(s);
      if (und) undn++;
      if (s == 0) check("resume fs", 32'(fs), 1);
    end
    check_words("resumed", 6);
    check("resume underruns", 32'(undn), 0);
    check("resume cnt", 32'(cnt), 3);

    // Underrun counter saturation.
    for (int k = 1; k <= 21; k++) begin
      undn = 0;
      for (int s = 0; s < 8; s++) begin
        tick;
        if (und) undn++;
      end
      check($sformatf("sat pulses k%0d", k), 32'(undn), 1);
      check($sformatf("sat cnt k%0d", k), 32'(cnt), (3 + k > 15) ? 15 : 3 + k);
    end

    // Reset mid-frame drops outputs at once and discards the pending sample.
    valid = 1'b1; set_stream(7);
    tick;
    set_stream(8);
    tick;
    valid = 1'b0;
    tick;
    check("pre-reset frame", 32'(frame), 1);
    #2 rst = 1'b1;
    #1;
    check("async lane", 32'(lane), 0);
    check("async frame", 32'(frame), 0);
    check("async fs", 32'(fs), 0);
    check("async cnt", 32'(cnt), 0);
    check("async ready", 32'(ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0; en = 1'b0;
    tick; tick;
    check("post-reset idle lane", 32'(lane), 0);
    check("post-reset idle frame", 32'(frame), 0);
    check("post-reset ready", 32'(ready), 1);
    en = 1'b1;
    tick;
    check("post-reset und", 32'(und), 1);
    check("post-reset cnt", 32'(cnt), 1);
    check("post-reset fs", 32'(fs), 1);
    check("post-reset lane", 32'(lane), 0);

`ifdef TX_TEST_PATTERN_EN
    tpat = 1'b1; undn = 0;
    repeat (7) tick;
    for (int s = 0; s < 8; s++) begin
      tick; take(s);
      if (und) undn++;
      check($sformatf("tpat frame slot%0d", s), 32'(frame), 32'(fp[7-s]));
    end
    check("tpat ch0", 32'(rxw[0]), 0);
    check("tpat ch1", 32'(rxw[1]), 0);
    check("tpat ch2", 32'(rxw[2]), 32'({14'h3FFF, 2'b00}));
    check("tpat ch3", 32'(rxw[3]), 32'({14'h1555, 2'b00}));
    check("tpat underruns", 32'(undn), 0);
    tpat = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
